// File: rtl/nios_system_Nios2_oci_pkg.sv
// Shared definitions for the Nios II OCI debug-memory control path:
// jdo field positions, the ocimem FSM states and default widths.
package nios_system_Nios2_oci_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned JDO_W      = 38;

  localparam int unsigned JDO_RD       = 35;
  localparam int unsigned JDO_ADDR_HI  = 33;
  localparam int unsigned JDO_ADDR_LO  = 26;
  localparam int unsigned JDO_CLR      = 25;
  localparam int unsigned JDO_WDATA_HI = 34;
  localparam int unsigned JDO_WDATA_LO = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2,
    WR       = 2'd3
  } ocimem_state_e;

endpackage

// File: rtl/nios_system_nios2_jtag_ocimem_ctrl.sv
// Turns JTAG take_action/take_no_action ocimem pulses into single-word
// debug RAM reads/writes; owns the auto-incrementing debug address.
module nios_system_nios2_jtag_ocimem_ctrl
  import nios_system_Nios2_oci_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              busy,
  output logic              ovr_err
);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mon_q, mon_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;
  logic              inc_q, inc_d;
  logic              any_pulse;
  logic              jdo_unused;

  assign jdo_unused = ^jdo[JDO_W-1:JDO_RD+1];
  assign any_pulse  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    re_d    = 1'b0;
    we_d    = 1'b0;
    ovr_d   = ovr_q;
    inc_d   = inc_q;

    unique case (state_q)
      IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[JDO_WDATA_HI:JDO_WDATA_LO];
          we_d    = 1'b1;
          state_d = WR;
          if (take_action_ocimem_a || take_no_action_ocimem_a) ovr_d = 1'b1;
        end else if (take_action_ocimem_a) begin
          addr_d = jdo[JDO_ADDR_HI:JDO_ADDR_LO];
          if (jdo[JDO_CLR]) ovr_d = 1'b0;
          if (jdo[JDO_RD]) begin
            re_d    = 1'b1;
            inc_d   = 1'b0;
            state_d = RD_ISSUE;
          end
          // A dropped no_action_a in the same cycle outranks the clear.
          if (take_no_action_ocimem_a) ovr_d = 1'b1;
        end else if (take_no_action_ocimem_a) begin
          re_d    = 1'b1;
          inc_d   = 1'b1;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        mon_d   = ram_rdata;
        if (inc_q) addr_d = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      WR: begin
        mon_d   = wdata_q;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && any_pulse) ovr_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mon_q   <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      re_q    <= re_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      inc_q   <= inc_d;
    end
  end

  // The live address register drives the RAM, so a load-and-read uses the new address.
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = we_q;
  assign ram_re    = re_q;
  assign MonDReg   = mon_q;
  assign busy      = busy_q;
  assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_nios_system_nios2_jtag_ocimem_ctrl.sv
// Directed vector bench for the ocimem controller with a 256x32 RAM model.
module tb_nios_system_nios2_jtag_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata, MonDReg;
  logic        ram_we, ram_re, busy, ovr_err;

  logic [31:0] mem [256];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  nios_system_nios2_jtag_ocimem_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a),
    .take_action_ocimem_b(ta_b),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_re(ram_re), .ram_rdata(ram_rdata), .MonDReg(MonDReg),
    .busy(busy), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic        a, na, b;
    logic [37:0] jdo;
    logic        re, we, busy, ovr;
    logic [7:0]  addr;
    logic [31:0] wdata, mon;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [37:0] ja(input logic rd, input logic clr, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[33:26] = a;
    j[25] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic add(input logic a, input logic na, input logic b, input logic [37:0] j,
                     input logic re, input logic we, input logic bz, input logic ov,
                     input logic [7:0] ad, input logic [31:0] wd, input logic [31:0] mo);
    vec_t v;
    v.a = a; v.na = na; v.b = b; v.jdo = j;
    v.re = re; v.we = we; v.busy = bz; v.ovr = ov;
    v.addr = ad; v.wdata = wd; v.mon = mo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, " ram_re"},    32'(ram_re),   32'(v.re));
    chk({tag, " ram_we"},    32'(ram_we),   32'(v.we));
    chk({tag, " busy"},      32'(busy),     32'(v.busy));
    chk({tag, " ovr_err"},   32'(ovr_err),  32'(v.ovr));
    chk({tag, " ram_addr"},  32'(ram_addr), 32'(v.addr));
    chk({tag, " ram_wdata"}, ram_wdata,     v.wdata);
    chk({tag, " MonDReg"},   MonDReg,       v.mon);
    chk({tag, " re_we_excl"}, 32'(ram_re & ram_we), 32'd0);
  endtask

  initial begin
    vec_t z;
    //   a  na b  jdo                      re we bz ov addr   wdata          mon
    add(0, 0, 0, '0,                      0, 0, 0, 0, 8'h00, 32'h0,         32'h0);
    add(1, 0, 0, ja(0, 0, 8'h10),         0, 0, 0, 0, 8'h10, 32'h0,         32'h0);
    add(0, 0, 1, jb(32'hDEADBEEF),        0, 1, 1, 0, 8'h10, 32'hDEADBEEF,  32'h0);
    add(0, 0, 0, '0,                      0, 0, 0, 0, 8'h11, 32'hDEADBEEF,  32'hDEADBEEF);
    add(1, 0, 0, ja(1, 0, 8'h10),         1, 0, 1, 0, 8'h10, 32'hDEADBEEF,  32'hDEADBEEF);
    add(0, 0, 0, '0,                      0, 0, 1, 0, 8'h10, 32'hDEADBEEF,  32'hDEADBEEF);
    add(0, 0, 0, '0,                      0, 0, 0, 0, 8'h10, 32'hDEADBEEF,  32'hDEADBEEF);
    add(1, 0, 0, ja(0, 0, 8'hFF),         0, 0, 0, 0, 8'hFF, 32'hDEADBEEF,  32'hDEADBEEF);
    add(0, 1, 0, '0,                      1, 0, 1, 0, 8'hFF, 32'hDEADBEEF,  32'hDEADBEEF);
    add(0, 0, 0, '0,                      0, 0, 1, 0, 8'hFF, 32'hDEADBEEF,  32'hDEADBEEF);
    add(0, 0, 0, '0,                      0, 0, 0, 0, 8'h00, 32'hDEADBEEF,  32'hA50000FF);
    add(0, 1, 0, '0,                      1, 0, 1, 0, 8'h00, 32'hDEADBEEF,  32'hA50000FF);
    add(0, 0, 0, '0,                      0, 0, 1, 0, 8'h00, 32'hDEADBEEF,  32'hA50000FF);
    add(0, 0, 0, '0,                      0, 0, 0, 0, 8'h01, 32'hDEADBEEF,  32'hA5000000);
    add(0, 1, 1, jb(32'h12345678),        0, 1, 1, 1, 8'h01, 32'h12345678,  32'hA5000000);
    add(0, 0, 0, '0,                      0, 0, 0, 1, 8'h02, 32'h12345678,  32'h12345678);
    add(1, 0, 0, ja(0, 1, 8'h01),         0, 0, 0, 0, 8'h01, 32'h12345678,  32'h12345678);
    add(0, 1, 0, '0,                      1, 0, 1, 0, 8'h01, 32'h12345678,  32'h12345678);
    add(0, 0, 1, jb(32'hCAFEF00D),        0, 0, 1, 1, 8'h01, 32'h12345678,  32'h12345678);
    add(0, 0, 0, '0,                      0, 0, 0, 1, 8'h02, 32'h12345678,  32'h12345678);
    add(1, 0, 0, ja(0, 1, 8'h30),         0, 0, 0, 0, 8'h30, 32'h12345678,  32'h12345678);
    add(1, 0, 0, ja(1, 0, 8'h02),         1, 0, 1, 0, 8'h02, 32'h12345678,  32'h12345678);
    add(0, 0, 0, '0,                      0, 0, 1, 0, 8'h02, 32'h12345678,  32'h12345678);
    add(0, 1, 0, '0,                      0, 0, 0, 1, 8'h02, 32'h12345678,  32'hA5000002);
    add(0, 0, 0, '0,                      0, 0, 0, 1, 8'h02, 32'h12345678,  32'hA5000002);
    add(1, 0, 0, ja(0, 1, 8'h40),         0, 0, 0, 0, 8'h40, 32'h12345678,  32'hA5000002);

    repeat (2) @(posedge clk);
    #1;
    z = '{a:0, na:0, b:0, jdo:'0, re:0, we:0, busy:0, ovr:0, addr:8'h00, wdata:32'h0, mon:32'h0};
    chk_all("in_reset", z);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      ta_a = vecs[i].a; tna_a = vecs[i].na; ta_b = vecs[i].b; jdo = vecs[i].jdo;
      @(posedge clk);
      #1;
      ta_a = 1'b0; tna_a = 1'b0; ta_b = 1'b0;
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while RD_ISSUE must kill the pending read strobe at once.
    tna_a = 1'b1;
    @(posedge clk);
    #1 tna_a = 1'b0;
    chk("issue ram_re pre", 32'(ram_re), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_issue ram_re", 32'(ram_re), 32'd0);
    chk("rst_issue busy", 32'(busy), 32'd0);
    chk("rst_issue addr", 32'(ram_addr), 32'd0);
    chk("rst_issue wdata", ram_wdata, 32'd0);
    chk("rst_issue mon", MonDReg, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset while RD_WAIT: no capture, MonDReg and addr cleared.
    ta_a = 1'b1; jdo = ja(1, 0, 8'h40);
    @(posedge clk);
    #1 ta_a = 1'b0;
    @(posedge clk);
    #1;
    chk("wait busy pre", 32'(busy), 32'd1);
    chk("wait rdata pre", ram_rdata, 32'hA5000040);
    #2 reset = 1'b1;
    #1;
    chk("rst_wait ram_re", 32'(ram_re), 32'd0);
    chk("rst_wait busy", 32'(busy), 32'd0);
    chk("rst_wait mon", MonDReg, 32'd0);
    chk("rst_wait addr", 32'(ram_addr), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst mon", MonDReg, 32'd0);
    chk("post_rst busy", 32'(busy), 32'd0);
    chk("post_rst addr", 32'(ram_addr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
